// File: rtl/fpu_pkg.sv
// Shared types and constants for the adder request initiator.
//   AddReqState : state encoding of the initiator control FSM
//   ADD_W       : operand / sum width of the adder handshake
package fpu_pkg;

    localparam int ADD_W = 25;

    typedef enum logic [1:0] {
        AR_IDLE,
        AR_REQ,
        AR_HOLD,
        AR_ERR
    } AddReqState;

endpackage

// File: rtl/add_req_initiator_if.sv
// Handshake bundle of add_req_initiator.
//   Upstream   : IN_VALID, IN_READY, IN_A, IN_B
//   Adder      : ADD_REQ, ADD_A, ADD_B (to responder), ADD_ACK, ADD_Z, ADD_COUT (from responder)
//   Downstream : OUT_VALID, OUT_READY, OUT_Z, OUT_COUT
//   Status     : ERR, ERR_CLR
// Modport master is the initiator side, slave is everything around it.
interface add_req_initiator_if;
    import fpu_pkg::*;

    logic             IN_VALID;
    logic             IN_READY;
    logic [ADD_W-1:0] IN_A;
    logic [ADD_W-1:0] IN_B;

    logic             ADD_REQ;
    logic [ADD_W-1:0] ADD_A;
    logic [ADD_W-1:0] ADD_B;
    logic             ADD_ACK;
    logic [ADD_W-1:0] ADD_Z;
    logic             ADD_COUT;

    logic             OUT_VALID;
    logic             OUT_READY;
    logic [ADD_W-1:0] OUT_Z;
    logic             OUT_COUT;

    logic             ERR;
    logic             ERR_CLR;

    modport master (
        input  IN_VALID, IN_A, IN_B,
        input  ADD_ACK, ADD_Z, ADD_COUT,
        input  OUT_READY, ERR_CLR,
        output IN_READY,
        output ADD_REQ, ADD_A, ADD_B,
        output OUT_VALID, OUT_Z, OUT_COUT,
        output ERR
    );

    modport slave (
        output IN_VALID, IN_A, IN_B,
        output ADD_ACK, ADD_Z, ADD_COUT,
        output OUT_READY, ERR_CLR,
        input  IN_READY,
        input  ADD_REQ, ADD_A, ADD_B,
        input  OUT_VALID, OUT_Z, OUT_COUT,
        input  ERR
    );

endinterface

// File: rtl/add_req_watchdog.sv
// Counts consecutive un-acknowledged request cycles.
//   CLK, RSTN : clock, asynchronous active-low reset
//   clear     : restart the count at zero
//   count_en  : this cycle is a request cycle without acknowledge
//   expired   : this cycle is the TIMEOUT-th such cycle (combinational)
// TIMEOUT must lie in 1..255 so the count fits in eight bits.
module add_req_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt holds the number of earlier missed cycles, so the current one is
    // the TIMEOUT-th when cnt has reached TIMEOUT-1.
    assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/add_req_initiator.sv
// Initiator side of a REQ/ACK adder handshake.
// Accepts an operand pair from upstream, presents it to the adder with
// ADD_REQ, captures sum/carry on ACK and holds them for downstream until
// consumed. A request left unanswered for TIMEOUT cycles parks the block
// in an error state until ERR_CLR.
//   CLK   : clock, rising edge
//   RSTN  : asynchronous active-low reset
//   bus   : add_req_initiator_if.master (upstream, adder and downstream sides)
// All outputs are registered and decoded from state; reset forces IDLE.
module add_req_initiator
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RSTN,
    add_req_initiator_if.master bus
);

    AddReqState       state;
    logic             in_ready_q;
    logic             add_req_q;
    logic             out_valid_q;
    logic             err_q;
    logic             out_cout_q;
    logic [ADD_W-1:0] add_a_q;
    logic [ADD_W-1:0] add_b_q;
    logic [ADD_W-1:0] out_z_q;

    logic accept;
    logic wd_clear;
    logic wd_count;
    logic wd_expired;

    assign accept   = (state == AR_IDLE) && bus.IN_VALID;
    assign wd_clear = accept || ((state == AR_ERR) && bus.ERR_CLR);
    assign wd_count = (state == AR_REQ) && !bus.ADD_ACK;

    add_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= AR_IDLE;
            in_ready_q  <= 1'b1;
            add_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_z_q     <= '0;
            out_cout_q  <= 1'b0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (bus.IN_VALID) begin
                        add_a_q    <= bus.IN_A;
                        add_b_q    <= bus.IN_B;
                        state      <= AR_REQ;
                        in_ready_q <= 1'b0;
                        add_req_q  <= 1'b1;
                    end
                end
                AR_REQ: begin
                    // ACK wins over an expiry landing in the same cycle;
                    // ADD_Z is only meaningful while ACK is high.
                    if (bus.ADD_ACK) begin
                        out_z_q     <= bus.ADD_Z;
                        out_cout_q  <= bus.ADD_COUT;
                        state       <= AR_HOLD;
                        add_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else if (wd_expired) begin
                        state     <= AR_ERR;
                        add_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                AR_HOLD: begin
                    // HOLD followed by IDLE keeps ADD_REQ low for at least
                    // two cycles, giving the responder its recovery cycle.
                    if (bus.OUT_READY) begin
                        state       <= AR_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                AR_ERR: begin
                    if (bus.ERR_CLR) begin
                        state      <= AR_IDLE;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= AR_IDLE;
                    in_ready_q  <= 1'b1;
                    add_req_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.ADD_REQ   = add_req_q;
    assign bus.ADD_A     = add_a_q;
    assign bus.ADD_B     = add_b_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_Z     = out_z_q;
    assign bus.OUT_COUT  = out_cout_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_add_req_initiator.sv
// Bench for add_req_initiator: a responder with programmable ACK delay,
// directed scenarios followed by randomized transactions, each checked
// against the transaction-level expectations of the handshake rules.
module tb_add_req_initiator;
    import fpu_pkg::*;

    localparam int TO = 15;

    logic CLK  = 1'b0;
    logic RSTN = 1'b1;

    add_req_initiator_if bus();

    add_req_initiator #(
        .TIMEOUT (TO)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Responder: answers after ack_delay REQ cycles with the true sum;
    // force_ack injects a stray ACK carrying a wrong result.
    int         ack_delay  = 0;
    logic       force_ack  = 1'b0;
    int         req_cycles = 0;
    logic [ADD_W:0] resp_sum;
    logic       resp_ack;

    assign resp_sum = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B};
    assign resp_ack = bus.ADD_REQ && (req_cycles >= ack_delay);
    assign bus.ADD_ACK = resp_ack | force_ack;
    assign {bus.ADD_COUT, bus.ADD_Z} = resp_ack  ? resp_sum :
                                       force_ack ? ~resp_sum : 26'h1555555;

    always @(posedge CLK) req_cycles <= bus.ADD_REQ ? req_cycles + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vectors++;
        assert (obs === expd)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    // One complete transaction. The expected REQ length and outcome follow
    // from the rules alone: ACK after `delay` misses succeeds when it lands
    // within TO cycles, otherwise the request expires after TO cycles.
    task automatic run_txn(input logic [ADD_W-1:0] a, input logic [ADD_W-1:0] b,
                           input int delay, input int hold,
                           output logic [ADD_W-1:0] z_o, output logic c_o);
        logic [ADD_W:0] expv;
        int  exp_n;
        int  n;
        int  budget;
        bit  ok;
        expv  = {1'b0, a} + {1'b0, b};
        ok    = (delay < TO);
        exp_n = ok ? delay + 1 : TO;
        z_o   = '0;
        c_o   = 1'b0;
        ack_delay = delay;
        budget = 0;
        while (!bus.IN_READY && budget < 50) begin
            @(negedge CLK);
            budget++;
        end
        check("in_ready_wait", 32'(bus.IN_READY), 1);
        bus.IN_VALID = 1'b1;
        bus.IN_A     = a;
        bus.IN_B     = b;
        @(negedge CLK);
        // keep offering different operands; they must not be taken
        bus.IN_A = ~a;
        bus.IN_B = ~b;
        n = 0;
        while (bus.ADD_REQ && n < 300) begin
            check("add_a_stable", 32'(bus.ADD_A), 32'(a));
            check("add_b_stable", 32'(bus.ADD_B), 32'(b));
            n++;
            @(negedge CLK);
        end
        check("req_cycles", n, exp_n);
        if (ok) begin
            z_o = bus.OUT_Z;
            c_o = bus.OUT_COUT;
            check("out_valid_rise", 32'(bus.OUT_VALID), 1);
            check("out_z", 32'(bus.OUT_Z), 32'(expv[ADD_W-1:0]));
            check("out_cout", 32'(bus.OUT_COUT), 32'(expv[ADD_W]));
            force_ack = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge CLK);
                check("hold_z", 32'(bus.OUT_Z), 32'(expv[ADD_W-1:0]));
                check("hold_cout", 32'(bus.OUT_COUT), 32'(expv[ADD_W]));
                check("hold_valid", 32'(bus.OUT_VALID), 1);
                check("hold_no_req", 32'(bus.ADD_REQ), 0);
                check("hold_not_ready", 32'(bus.IN_READY), 0);
                check("hold_add_a", 32'(bus.ADD_A), 32'(a));
            end
            force_ack     = 1'b0;
            bus.OUT_READY = 1'b1;
            bus.IN_VALID  = 1'b0;
            @(negedge CLK);
            bus.OUT_READY = 1'b0;
            check("consumed_valid", 32'(bus.OUT_VALID), 0);
            check("consumed_ready", 32'(bus.IN_READY), 1);
        end else begin
            check("err_set", 32'(bus.ERR), 1);
            check("err_not_ready", 32'(bus.IN_READY), 0);
            check("err_no_req", 32'(bus.ADD_REQ), 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                check("err_sticky", 32'(bus.ERR), 1);
                check("err_add_a", 32'(bus.ADD_A), 32'(a));
            end
            bus.IN_VALID = 1'b0;
            bus.ERR_CLR  = 1'b1;
            @(negedge CLK);
            bus.ERR_CLR = 1'b0;
            check("err_cleared", 32'(bus.ERR), 0);
            check("err_clr_ready", 32'(bus.IN_READY), 1);
        end
        bus.IN_VALID = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within its time budget");
        $fatal(1);
    end

    initial begin
        logic [ADD_W-1:0] z;
        logic             c;
        logic [ADD_W-1:0] ra;
        logic [ADD_W-1:0] rb;
        logic [ADD_W-1:0] z_before;
        int               rd;
        int               rh;

        bus.IN_VALID  = 1'b0;
        bus.IN_A      = '0;
        bus.IN_B      = '0;
        bus.OUT_READY = 1'b0;
        bus.ERR_CLR   = 1'b0;

        // reset state
        #2 RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_add_req", 32'(bus.ADD_REQ), 0);
        check("rst_add_a", 32'(bus.ADD_A), 0);
        check("rst_add_b", 32'(bus.ADD_B), 0);
        check("rst_out_valid", 32'(bus.OUT_VALID), 0);
        check("rst_out_z", 32'(bus.OUT_Z), 0);
        check("rst_out_cout", 32'(bus.OUT_COUT), 0);
        check("rst_err", 32'(bus.ERR), 0);
        check("rst_in_ready", 32'(bus.IN_READY), 1);
        RSTN = 1'b1;
        @(negedge CLK);

        // immediate ACK, small operands, one-cycle latency
        run_txn(25'h0000001, 25'h0000002, 0, 2, z, c);
        check("dir_small_z", 32'(z), 32'h0000003);
        check("dir_small_cout", 32'(c), 0);

        // carry out of the top bit
        run_txn(25'h1FFFFFF, 25'h0000001, 0, 0, z, c);
        check("dir_carry_z", 32'(z), 32'h0000000);
        check("dir_carry_cout", 32'(c), 1);

        // ACK delayed by three cycles: four REQ cycles
        run_txn(25'h0123456, 25'h0654321, 3, 1, z, c);
        check("dir_delay_z", 32'(z), 32'h0777777);
        check("dir_delay_cout", 32'(c), 0);

        // no ACK: timeout after exactly TO cycles, then ERR_CLR
        run_txn(25'h0ABCDEF, 25'h0111111, 1000, 0, z, c);

        // ACK on the last allowed cycle beats the timeout
        run_txn(25'h1000000, 25'h1000000, TO - 1, 0, z, c);
        check("dir_edge_z", 32'(z), 32'h0000000);
        check("dir_edge_cout", 32'(c), 1);

        // downstream stalls for five cycles while upstream keeps offering
        run_txn(25'h0F0F0F0, 25'h00F0F0F, 0, 5, z, c);
        check("dir_stall_z", 32'(z), 32'h0FFFFFF);

        // stray ACK while idle is ignored
        z_before  = bus.OUT_Z;
        force_ack = 1'b1;
        repeat (2) @(negedge CLK);
        force_ack = 1'b0;
        check("idle_ack_ready", 32'(bus.IN_READY), 1);
        check("idle_ack_valid", 32'(bus.OUT_VALID), 0);
        check("idle_ack_z", 32'(bus.OUT_Z), 32'(z_before));

        // reset in the middle of a request
        ack_delay    = 1000;
        bus.IN_VALID = 1'b1;
        bus.IN_A     = 25'h1234567;
        bus.IN_B     = 25'h0000111;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("mid_req_active", 32'(bus.ADD_REQ), 1);
        #2 RSTN = 1'b0;
        #1;
        check("async_add_req", 32'(bus.ADD_REQ), 0);
        check("async_add_a", 32'(bus.ADD_A), 0);
        check("async_add_b", 32'(bus.ADD_B), 0);
        check("async_out_valid", 32'(bus.OUT_VALID), 0);
        check("async_out_z", 32'(bus.OUT_Z), 0);
        check("async_err", 32'(bus.ERR), 0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        check("post_rst_ready", 32'(bus.IN_READY), 1);
        check("post_rst_req", 32'(bus.ADD_REQ), 0);
        run_txn(25'h0000010, 25'h0000020, 0, 0, z, c);
        check("post_rst_z", 32'(z), 32'h0000030);

        // randomized transactions, occasionally left unanswered
        for (int k = 0; k < 24; k++) begin
            ra = ADD_W'($urandom);
            rb = ADD_W'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 5));
            rh = int'($urandom_range(0, 3));
            run_txn(ra, rb, rd, rh, z, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
